// File: rtl/sdram_aref_if.sv
// Handshake and command bus between the auto-refresh block and the SDRAM
// command arbiter / init stage.
interface sdram_aref_if #(
  parameter int ADDR_BITS = 12
);
  logic                 init_done;
  logic                 aref_en;
  logic                 aref_req;
  logic                 aref_end;
  logic [3:0]           aref_cmd;
  logic [ADDR_BITS-1:0] aref_addr;
  logic                 aref_miss;

  // arbiter / init side
  modport master (
    output init_done, aref_en,
    input  aref_req, aref_end, aref_cmd, aref_addr, aref_miss
  );

  // refresh block side
  modport slave (
    input  init_done, aref_en,
    output aref_req, aref_end, aref_cmd, aref_addr, aref_miss
  );
endinterface

// File: rtl/sdram_aref.sv
// SDRAM auto-refresh generator: periodic request, then PRECHARGE-all,
// tRP wait, AUTO-REFRESH, tRFC wait and a one-cycle end pulse.
module sdram_aref #(
  parameter int REF_INTERVAL = 1040,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 9,
  parameter int ADDR_BITS    = 12
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  sdram_aref_if.slave  bus
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  // A10 high selects all banks for PRECHARGE; harmless for the other commands
  localparam logic [ADDR_BITS-1:0] ADDR_PALL = ADDR_BITS'(1 << 10);

  localparam int RW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam int CW = $clog2((T_RFC > T_RP) ? T_RFC : T_RP) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
  logic [RW-1:0]   ref_cnt;
  logic            aref_req;
  logic            aref_miss;
  logic            expiry;
  logic            grant;
  logic [3:0]      cmd;

  assign expiry = bus.init_done && (ref_cnt == RW'(REF_INTERVAL - 1));
  // aref_en only matters when a request is pending and nothing is in flight
  assign grant  = bus.aref_en && aref_req && (state == S_IDLE);

  // Interval counter: parked at 0 until init completes, wraps on expiry
  always_ff @(posedge sys_clk) begin
    if (sys_rst)             ref_cnt <= '0;
    else if (!bus.init_done) ref_cnt <= '0;
    else if (expiry)         ref_cnt <= '0;
    else                     ref_cnt <= ref_cnt + RW'(1);
  end

  // Single pending request; a coincident expiry beats the grant clear
  always_ff @(posedge sys_clk) begin
    if (sys_rst)     aref_req <= 1'b0;
    else if (expiry) aref_req <= 1'b1;
    else if (grant)  aref_req <= 1'b0;
  end

  // Sticky overrun flag: an interval ran out with the previous one unserved
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                              aref_miss <= 1'b0;
    else if (expiry && aref_req && !grant)    aref_miss <= 1'b1;
  end

  // FSM state and wait counter registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and command decode; once started, the sequence only ends in DONE
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    cmd          = CMD_NOP;
    unique case (state)
      S_IDLE: begin
        if (grant) state_nxt = S_PRE;
      end
      S_PRE: begin
        cmd          = CMD_PRE;
        wait_cnt_nxt = '0;
        state_nxt    = (T_RP > 1) ? S_WAIT_RP : S_AREF;
      end
      S_WAIT_RP: begin
        if (wait_cnt == CW'(T_RP - 2)) state_nxt = S_AREF;
        else                           wait_cnt_nxt = wait_cnt + CW'(1);
      end
      S_AREF: begin
        cmd          = CMD_AREF;
        wait_cnt_nxt = '0;
        state_nxt    = (T_RFC > 1) ? S_WAIT_RFC : S_DONE;
      end
      S_WAIT_RFC: begin
        if (wait_cnt == CW'(T_RFC - 2)) state_nxt = S_DONE;
        else                            wait_cnt_nxt = wait_cnt + CW'(1);
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.aref_req  = aref_req;
  assign bus.aref_miss = aref_miss;
  assign bus.aref_end  = (state == S_DONE);
  assign bus.aref_cmd  = cmd;
  assign bus.aref_addr = ADDR_PALL;

endmodule

// File: tb/tb_sdram_aref.sv
// Directed bench for sdram_aref with REF_INTERVAL=20, T_RP=3, T_RFC=9.
// Cycle k of a scenario is the k-th clock period after init_done is raised.
module tb_sdram_aref;

  localparam int AB = 12;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam int NC = 128;

  logic sys_clk = 1'b0;
  logic sys_rst;

  always #5 sys_clk = ~sys_clk;

  sdram_aref_if #(.ADDR_BITS(AB)) bus();

  sdram_aref #(
    .REF_INTERVAL(20), .T_RP(3), .T_RFC(9), .ADDR_BITS(AB)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_bad;

  logic       req_h  [NC];
  logic       end_h  [NC];
  logic       miss_h [NC];
  logic [3:0] cmd_h  [NC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst       = 1'b1;
    bus.init_done = 1'b0;
    bus.aref_en   = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  function automatic int n_cmd(input int lo, input int hi, input logic [3:0] c);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cmd_h[i] === c) n++;
    return n;
  endfunction

  function automatic int n_end(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (end_h[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int n_req(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (req_h[i] === 1'b1) n++;
    return n;
  endfunction

  // Drive per-cycle inputs for scenario sc, record outputs, advance a clock
  task automatic run(input int sc, input int n);
    n_bad = 0;
    for (int k = 0; k < n; k++) begin
      sys_rst       = 1'b0;
      bus.init_done = (sc != 1);
      case (sc)
        1:       bus.aref_en = 1'b0;
        2:       bus.aref_en = 1'b1;
        3:       bus.aref_en = (k >= 45);
        4:       bus.aref_en = (k == 20 || k == 28);
        5:       bus.aref_en = (k >= 39);
        default: begin
          bus.aref_en = 1'b1;
          sys_rst     = (k == 25);
        end
      endcase
      req_h[k]  = bus.aref_req;
      end_h[k]  = bus.aref_end;
      miss_h[k] = bus.aref_miss;
      cmd_h[k]  = bus.aref_cmd;
      if (!(bus.aref_cmd inside {NOP, PRE, AREF}) || bus.aref_addr !== 12'h400) n_bad++;
      tick();
    end
  endtask

  initial begin
    sys_rst       = 1'b1;
    bus.init_done = 1'b0;
    bus.aref_en   = 1'b0;

    // reset state
    do_reset();
    chk("rst_req",  bus.aref_req,  1'b0);
    chk("rst_end",  bus.aref_end,  1'b0);
    chk("rst_miss", bus.aref_miss, 1'b0);
    chk("rst_cmd",  bus.aref_cmd,  NOP);
    chk("rst_addr", bus.aref_addr, 12'h400);

    // 1: no init -> nothing happens
    run(1, 100);
    chk("s1_req_cnt", n_req(0, 99), 0);
    chk("s1_nop_cnt", n_cmd(0, 99, NOP), 100);
    chk("s1_bad", n_bad, 0);

    // 2: grant tied high
    do_reset();
    run(2, 46);
    chk("s2_req19",  req_h[19], 1'b0);
    chk("s2_req20",  req_h[20], 1'b1);
    chk("s2_req21",  req_h[21], 1'b0);
    chk("s2_pre21",  cmd_h[21], PRE);
    chk("s2_nop23",  cmd_h[23], NOP);
    chk("s2_aref24", cmd_h[24], AREF);
    chk("s2_end32",  end_h[32], 1'b0);
    chk("s2_end33",  end_h[33], 1'b1);
    chk("s2_endcnt", n_end(0, 39), 1);
    chk("s2_req39",  req_h[39], 1'b0);
    chk("s2_req40",  req_h[40], 1'b1);
    chk("s2_pre41",  cmd_h[41], PRE);
    chk("s2_miss",   miss_h[45], 1'b0);
    chk("s2_bad",    n_bad, 0);

    // 3: grant withheld past a second interval
    do_reset();
    run(3, 70);
    chk("s3_req20",   req_h[20], 1'b1);
    chk("s3_req44",   req_h[44], 1'b1);
    chk("s3_miss39",  miss_h[39], 1'b0);
    chk("s3_miss40",  miss_h[40], 1'b1);
    chk("s3_pre_pre", n_cmd(0, 45, PRE), 0);
    chk("s3_pre46",   cmd_h[46], PRE);
    chk("s3_pre_cnt", n_cmd(0, 60, PRE), 1);
    chk("s3_miss69",  miss_h[69], 1'b1);

    // 4: stray grant pulse inside WAIT_RFC
    do_reset();
    run(4, 40);
    chk("s4_pre_cnt",  n_cmd(0, 39, PRE), 1);
    chk("s4_aref_cnt", n_cmd(0, 39, AREF), 1);
    chk("s4_req29",    req_h[29], 1'b0);
    chk("s4_end33",    end_h[33], 1'b1);

    // 5: expiry on the grant cycle -> back-to-back sequences
    do_reset();
    run(5, 60);
    chk("s5_pre40",  cmd_h[40], PRE);
    chk("s5_req40",  req_h[40], 1'b1);
    chk("s5_req52",  req_h[52], 1'b1);
    chk("s5_aref43", cmd_h[43], AREF);
    chk("s5_end52",  end_h[52], 1'b1);
    chk("s5_pre54",  cmd_h[54], PRE);
    chk("s5_req55",  req_h[55], 1'b0);
    chk("s5_miss",   miss_h[59], 1'b0);

    // 6: reset the cycle after AREF
    do_reset();
    run(6, 50);
    chk("s6_aref24", cmd_h[24], AREF);
    chk("s6_nop26",  cmd_h[26], NOP);
    chk("s6_endcnt", n_end(20, 49), 0);
    chk("s6_req40",  req_h[40], 1'b0);
    chk("s6_req45",  req_h[45], 1'b0);
    chk("s6_req46",  req_h[46], 1'b1);
    chk("s6_pre47",  cmd_h[47], PRE);
    chk("s6_miss",   miss_h[49], 1'b0);
    chk("s6_bad",    n_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_aref.md
SDRAM_AREF -- requirements
Module: sdram_aref

Interface
REQ-001 Parameter REF_INTERVAL, default 1040, sets the cycles between refresh requests (7.8 us at 7.5 ns sys_clk).
REQ-002 Parameter T_RP, default 3, sets the PRECHARGE-to-AUTO-REFRESH spacing in cycles.
REQ-003 Parameter T_RFC, default 9, sets the AUTO-REFRESH-to-end spacing in cycles.
REQ-004 Parameter ADDR_BITS, default 12, sets the SDRAM address width.
REQ-005 sys_clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 sys_rst  input  1  reset, synchronous and active-high.
REQ-007 init_done  input  1  high once SDRAM initialization is complete; level, from the init stage.
REQ-008 aref_en  input  1  grant from the command arbiter.
REQ-009 aref_req  output  1  refresh request to the arbiter.
REQ-010 aref_end  output  1  one-cycle pulse marking refresh sequence completion.
REQ-011 aref_cmd  output  4  SDRAM command {CS_n, RAS_n, CAS_n, WE_n}.
REQ-012 aref_addr  output  ADDR_BITS  SDRAM address bus value.
REQ-013 aref_miss  output  1  sticky flag indicating an interval expired while a request was still unserved.

Function
REQ-014 Command encodings: NOP 4'b0111, PRE 4'b0010, AREF 4'b0001; no other command is ever driven.
REQ-015 aref_addr is 0x400 (A10=1, precharge all banks) in every cycle, for all commands.
REQ-016 Interval counter ref_cnt is held at 0 while init_done=0 and increments each cycle while init_done=1.
REQ-017 Interval counter expiry: ref_cnt==REF_INTERVAL-1 is an expiry; ref_cnt wraps to 0 on the next cycle.
REQ-018 First expiry: the first expiry occurs REF_INTERVAL cycles after init_done first samples high.
REQ-019 FSM states: IDLE, PRE, WAIT_RP, AREF, WAIT_RFC, DONE; all outputs are decoded from registered state/flags, with no combinational input-to-output path.
REQ-020 aref_req sets on the cycle after an expiry and clears on the cycle after grant acceptance.
REQ-021 Set/clear collision: if an expiry and a grant acceptance occur in the same cycle, the set wins and aref_req stays 1.
REQ-022 Grant acceptance is aref_en=1 AND aref_req=1 AND state=IDLE; aref_en is ignored in every other case.
REQ-023 Grant accepted at cycle T: T+1 is PRE (aref_cmd=PRE); AREF (aref_cmd=AREF) at T+1+T_RP; DONE (aref_end=1) at T+1+T_RP+T_RFC; IDLE the cycle after.
REQ-024 aref_cmd is NOP in IDLE, WAIT_RP, WAIT_RFC and DONE; WAIT_RP lasts T_RP-1 cycles and WAIT_RFC lasts T_RFC-1 cycles.
REQ-025 A started sequence always completes: aref_en or init_done dropping mid-sequence does not abort it.
REQ-026 An expiry during a sequence (state not IDLE) only sets aref_req; the new request is served after return to IDLE.
REQ-027 aref_miss sets when an expiry occurs while aref_req=1 and no grant is accepted that cycle; it remains 1 until reset.
REQ-028 Refresh requests do not accumulate: at most one pending request exists.

Reset
REQ-029 sys_rst=1 at a rising edge forces state=IDLE, ref_cnt=0, aref_req=0, aref_end=0, aref_miss=0, aref_cmd=NOP and aref_addr=0x400, regardless of the current state.
REQ-030 Reset asserted mid-sequence abandons the sequence: the next cycle drives NOP and no aref_end is issued.
REQ-031 After reset releases, the interval restarts from 0 once init_done=1.

Verification (REF_INTERVAL=20, T_RP=3, T_RFC=9)
REQ-032 Scenario 1: init_done=0 for 100 cycles -> aref_req=0 and aref_cmd=NOP throughout.
REQ-033 Scenario 2: init_done rises at cycle 0, aref_en tied to 1 -> aref_req=1 at cycle 20, PRE at 21, AREF at 24, aref_end at 33, next aref_req at 40.
REQ-034 Scenario 3: aref_en held 0 for 45 cycles after init_done -> aref_req high from cycle 20, aref_miss=1 from cycle 40, a single PRE only after the grant.
REQ-035 Scenario 4: aref_en pulsed 1 for one cycle during WAIT_RFC -> no effect; exactly one PRE/AREF pair per accepted grant.
REQ-036 Scenario 5: expiry coincides with the grant cycle -> aref_req stays 1 after PRE, and a second sequence follows immediately after return to IDLE.
REQ-037 Scenario 6: sys_rst pulsed the cycle after AREF -> NOP next cycle, no aref_end, all outputs at reset values, interval restarts.
